// File: rtl/tone_gen_pkg.sv
// Shared types and constant tables for the tone generator.
// TONE_INC holds the per-symbol phase increments for a 24-bit accumulator
// at Fs = 48 kHz. SINE_Q is one quarter of a 256-point sine wave at 16-bit
// full scale. rampGain is only used when TONE_GEN_RAMP_EN is defined.
package tone_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [15:0] FULL_SCALE = 16'd32767;

    localparam logic [31:0] TONE_INC [0:7] = '{
        32'd174763, 32'd244668, 32'd314573, 32'd384478,
        32'd454383, 32'd524288, 32'd594193, 32'd664098
    };

    localparam logic [15:0] SINE_Q [0:63] = '{
        16'd0,     16'd804,   16'd1608,  16'd2410,  16'd3212,  16'd4011,  16'd4808,  16'd5602,
        16'd6393,  16'd7179,  16'd7962,  16'd8739,  16'd9512,  16'd10278, 16'd11039, 16'd11793,
        16'd12539, 16'd13279, 16'd14010, 16'd14732, 16'd15446, 16'd16151, 16'd16846, 16'd17530,
        16'd18204, 16'd18868, 16'd19519, 16'd20159, 16'd20787, 16'd21403, 16'd22005, 16'd22594,
        16'd23170, 16'd23731, 16'd24279, 16'd24811, 16'd25329, 16'd25832, 16'd26319, 16'd26790,
        16'd27245, 16'd27683, 16'd28105, 16'd28510, 16'd28898, 16'd29268, 16'd29621, 16'd29956,
        16'd30273, 16'd30571, 16'd30852, 16'd31113, 16'd31356, 16'd31580, 16'd31785, 16'd31971,
        16'd32137, 16'd32285, 16'd32412, 16'd32521, 16'd32609, 16'd32678, 16'd32728, 16'd32757
    };

    // Envelope gain for sample k of a tone of length len: min(k, len-1-k, cap).
    // Callers guarantee k <= len-1, so the remaining count never underflows.
    function automatic logic [31:0] rampGain(input logic [31:0] k,
                                             input logic [31:0] len,
                                             input logic [31:0] cap);
        logic [31:0] remaining;
        logic [31:0] gain;
        remaining = len - 32'd1 - k;
        gain      = (k < remaining) ? k : remaining;
        if (gain > cap) begin
            gain = cap;
        end
        return gain;
    endfunction

endpackage

// File: rtl/tone_sine_rom.sv
// Quarter-wave sine lookup with a registered output.
// idx_i[7:6] selects the quadrant: odd quadrants read the table mirrored,
// quadrants 2 and 3 are negated. zero_i forces the registered sample to 0
// so gap samples can travel down the same pipeline as tone samples.
module tone_sine_rom
    import tone_gen_pkg::*;
#(
    parameter int SAMPLE_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [7:0]                 idx_i,
    input  logic                       zero_i,
    output logic signed [SAMPLE_W-1:0] sample_o
);

    logic [5:0]                 lowIdx;
    logic [15:0]                magnitude;
    logic signed [16:0]         signedVal;
    logic signed [SAMPLE_W-1:0] sample_d;
    logic signed [SAMPLE_W-1:0] sample_q;

    // Fold the 8-bit phase index onto the quarter-wave table and apply the sign.
    always_comb begin
        lowIdx = idx_i[5:0];
        if (idx_i[6]) begin
            lowIdx = 6'(7'd64 - {1'b0, idx_i[5:0]});
        end
        magnitude = SINE_Q[lowIdx];
        if (idx_i[6] && (idx_i[5:0] == 6'd0)) begin
            magnitude = FULL_SCALE;
        end
        signedVal = $signed({1'b0, magnitude});
        if (idx_i[7]) begin
            signedVal = -signedVal;
        end
        sample_d = SAMPLE_W'(signedVal);
        if (zero_i) begin
            sample_d = '0;
        end
    end

    // Register the looked-up sample; this is the second pipeline stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sample_q <= '0;
        end else begin
            sample_q <= sample_d;
        end
    end

    assign sample_o = sample_q;

endmodule

// File: rtl/tone_gen_fsm.sv
// Tone-link transmitter: one DDS sine burst per accepted 3-bit symbol,
// followed by GAP_LEN zero samples.
// Pipeline: tick -> phase/index register -> registered ROM read (2 cycles).
// Optional macro TONE_GEN_RAMP_EN adds a linear attack/decay envelope and a
// third pipeline stage holding the scaled sample.
module tone_gen_fsm
    import tone_gen_pkg::*;
#(
    parameter int PHASE_W  = 24,
    parameter int SAMPLE_W = 16,
    parameter int GAP_LEN  = 16
`ifdef TONE_GEN_RAMP_EN
    ,
    parameter int RAMP_SHIFT = 4
`endif
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [2:0]                 tone_ident,
    input  logic                       tone_valid_in,
    output logic                       tone_ready_out,
    input  logic [31:0]                recording_length,
    input  logic                       sample_tick_in,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_valid_out,
    output logic                       busy_out,
    output logic                       symbol_done_out
);

    localparam logic [31:0] GAP_LAST = (GAP_LEN > 0) ? 32'(GAP_LEN - 1) : 32'd0;

    state_t               state_q;
    logic [2:0]           ident_q;
    logic [31:0]          len_q;
    logic [PHASE_W-1:0]   inc_q;
    logic [PHASE_W-1:0]   phase_q;
    logic [31:0]          count_q;
    logic [31:0]          gapCnt_q;
    logic                 ready_q;
    logic                 done_q;
    logic [7:0]           idx1_q;
    logic                 zero1_q;
    logic                 vld1_q;
    logic                 vld2_q;
    logic signed [SAMPLE_W-1:0] romSample;

`ifdef TONE_GEN_RAMP_EN
    localparam int          GAIN_W   = RAMP_SHIFT + 1;
    localparam int          PROD_W   = SAMPLE_W + GAIN_W + 1;
    localparam logic [31:0] RAMP_MAX = 32'(1) << RAMP_SHIFT;

    logic [GAIN_W-1:0]          gain1_q;
    logic [GAIN_W-1:0]          gain2_q;
    logic                       vld3_q;
    logic signed [SAMPLE_W-1:0] sample3_q;
    logic signed [PROD_W-1:0]   product_d;
`endif

    // Symbol FSM plus the first pipeline stage (phase index capture on each tick).
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            ident_q  <= '0;
            len_q    <= '0;
            inc_q    <= '0;
            phase_q  <= '0;
            count_q  <= '0;
            gapCnt_q <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            idx1_q   <= '0;
            zero1_q  <= 1'b0;
            vld1_q   <= 1'b0;
`ifdef TONE_GEN_RAMP_EN
            gain1_q  <= '0;
`endif
        end else begin
            vld1_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ready_q && tone_valid_in) begin
                        ident_q <= tone_ident;
                        len_q   <= recording_length;
                        ready_q <= 1'b0;
                        state_q <= LOAD;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    inc_q    <= PHASE_W'(TONE_INC[ident_q]);
                    phase_q  <= '0;
                    count_q  <= '0;
                    gapCnt_q <= '0;
                    state_q  <= (len_q == 32'd0) ? GAP : PLAY;
                end
                PLAY: begin
                    if (sample_tick_in) begin
                        idx1_q  <= phase_q[PHASE_W-1 -: 8];
                        zero1_q <= 1'b0;
                        vld1_q  <= 1'b1;
                        phase_q <= phase_q + inc_q;
                        count_q <= count_q + 32'd1;
`ifdef TONE_GEN_RAMP_EN
                        gain1_q <= GAIN_W'(rampGain(count_q, len_q, RAMP_MAX));
`endif
                        if (count_q == len_q - 32'd1) begin
                            state_q <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (GAP_LEN == 0) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else if (sample_tick_in) begin
                        zero1_q <= 1'b1;
                        vld1_q  <= 1'b1;
`ifdef TONE_GEN_RAMP_EN
                        gain1_q <= '0;
`endif
                        if (gapCnt_q == GAP_LAST) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            gapCnt_q <= gapCnt_q + 32'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Second stage: valid flag travels alongside the registered ROM read.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vld2_q <= 1'b0;
        end else begin
            vld2_q <= vld1_q;
        end
    end

    tone_sine_rom #(
        .SAMPLE_W (SAMPLE_W)
    ) u_rom (
        .clk_i    (clk_in),
        .rst_i    (rst_in),
        .idx_i    (idx1_q),
        .zero_i   (zero1_q),
        .sample_o (romSample)
    );

`ifdef TONE_GEN_RAMP_EN
    // Envelope multiply of the ROM sample by its gain (gain in units of 2**-RAMP_SHIFT).
    always_comb begin
        product_d = PROD_W'(romSample) * PROD_W'($signed({1'b0, gain2_q}));
    end

    // Third stage: keep gain aligned with the ROM read, then register the scaled sample.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            gain2_q   <= '0;
            vld3_q    <= 1'b0;
            sample3_q <= '0;
        end else begin
            gain2_q   <= gain1_q;
            vld3_q    <= vld2_q;
            sample3_q <= SAMPLE_W'(product_d >>> RAMP_SHIFT);
        end
    end

    assign sample_out       = sample3_q;
    assign sample_valid_out = vld3_q;
`else
    assign sample_out       = romSample;
    assign sample_valid_out = vld2_q;
`endif

    assign tone_ready_out  = ready_q;
    assign busy_out        = (state_q != IDLE);
    assign symbol_done_out = done_q;

endmodule

// File: tb/tb_tone_gen_fsm.sv
// Directed bench for tone_gen_fsm. Main instance uses GAP_LEN=16, a second
// instance uses GAP_LEN=0 for the immediate-done case. Expected samples are
// hand-computed from the DDS increments and the quarter-wave table; the
// envelope is applied on top when TONE_GEN_RAMP_EN is defined.
module tb_tone_gen_fsm;

`ifdef TONE_GEN_RAMP_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [2:0]         toneIdent;
    logic               toneValid;
    logic               toneValid0;
    logic [31:0]        recLen;
    logic               tick;

    logic               ready;
    logic signed [15:0] sampleOut;
    logic               sampleValid;
    logic               busy;
    logic               done;

    logic               ready0;
    logic signed [15:0] sample0;
    logic               sampleValid0;
    logic               busy0;
    logic               done0;

    int checks = 0;
    int failures = 0;
    int acceptCnt = 0;
    int accept0Cnt = 0;
    int doneCnt = 0;
    int done0Cnt = 0;
    int doneAtAccept = 0;
    bit dropPending;
    bit drop0Pending;

    always #5 clk = ~clk;

    tone_gen_fsm #(
        .GAP_LEN (16)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .tone_ident       (toneIdent),
        .tone_valid_in    (toneValid),
        .tone_ready_out   (ready),
        .recording_length (recLen),
        .sample_tick_in   (tick),
        .sample_out       (sampleOut),
        .sample_valid_out (sampleValid),
        .busy_out         (busy),
        .symbol_done_out  (done)
    );

    tone_gen_fsm #(
        .GAP_LEN (0)
    ) dut0 (
        .clk_in           (clk),
        .rst_in           (rst),
        .tone_ident       (toneIdent),
        .tone_valid_in    (toneValid0),
        .tone_ready_out   (ready0),
        .recording_length (recLen),
        .sample_tick_in   (tick),
        .sample_out       (sample0),
        .sample_valid_out (sampleValid0),
        .busy_out         (busy0),
        .symbol_done_out  (done0)
    );

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected output for a tone sample of index k in a tone of length len.
    function automatic longint expTone(input longint base, input int k, input int len);
`ifdef TONE_GEN_RAMP_EN
        longint g;
        g = (k < len - 1 - k) ? k : len - 1 - k;
        if (g > 16) g = 16;
        return (base * g) >>> 4;
`else
        return base;
`endif
    endfunction

    // Tone 5 steps the 8-bit ROM index by 8 per sample.
    function automatic longint sweepBase(input int k);
        int q [0:8];
        q = '{0, 6393, 12539, 18204, 23170, 27245, 30273, 32137, 32767};
        if (k <= 8)  return q[k];
        if (k <= 16) return q[16 - k];
        return -q[k - 16];
    endfunction

    // Advance to the next falling edge, dropping valid after a handshake.
    task automatic stepCycle();
        dropPending  = toneValid && ready;
        drop0Pending = toneValid0 && ready0;
        @(negedge clk);
        if (dropPending) begin
            toneValid    = 1'b0;
            acceptCnt++;
            doneAtAccept = doneCnt;
        end
        if (drop0Pending) begin
            toneValid0 = 1'b0;
            accept0Cnt++;
        end
        if (done)  doneCnt++;
        if (done0) done0Cnt++;
    endtask

    // One sample tick followed by a 10-cycle window; checks latency and value.
    task automatic applyStimulus(input string tag, input bit expectValid, input longint exp);
        int unsigned mask;
        longint      got;
        mask = 0;
        got  = 0;
        tick = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            stepCycle();
            tick = 1'b0;
            if (sampleValid) begin
                mask |= (32'd1 << i);
                if (i == LAT) got = sampleOut;
            end
        end
        if (expectValid) begin
            checkOutput($sformatf("%s_valid_timing", tag), mask, 32'd1 << LAT);
            checkOutput($sformatf("%s_sample", tag), got, exp);
        end else begin
            checkOutput($sformatf("%s_no_valid", tag), mask, 0);
        end
    endtask

    task automatic sendSymbol(input logic [2:0] ident, input logic [31:0] len);
        int start;
        int n;
        start     = acceptCnt;
        n         = 0;
        toneIdent = ident;
        recLen    = len;
        toneValid = 1'b1;
        while (acceptCnt == start && n < 100) begin
            stepCycle();
            n++;
        end
        checkOutput("accept", acceptCnt - start, 1);
    endtask

    task automatic gapTicks(input string tag);
        for (int g = 0; g < 16; g++) begin
            applyStimulus($sformatf("%s_gap%0d", tag, g), 1'b1, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int d0;
        int a0;
        int n;
        bit seen;
        int toneA [0:3];
        int toneB [0:3];
        int toneC [0:3];
        toneA = '{0, 6393, 12539, 18204};
        toneB = '{0, 1608, 4011, 6393};
        toneC = '{0, 7962, 15446, 22005};

        rst        = 1'b1;
        toneIdent  = '0;
        toneValid  = 1'b0;
        toneValid0 = 1'b0;
        recLen     = '0;
        tick       = 1'b0;

        // Reset state
        repeat (3) stepCycle();
        checkOutput("rst_ready", ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_valid", sampleValid, 0);
        checkOutput("rst_sample", sampleOut, 0);
        checkOutput("rst_done", done, 0);
        rst = 1'b0;
        #1;
        checkOutput("ready_before_edge", ready, 0);
        stepCycle();
        checkOutput("ready_after_release", ready, 1);
        checkOutput("ready0_after_release", ready0, 1);
        checkOutput("idle_busy", busy, 0);
        applyStimulus("idle_tick", 1'b0, 0);

        // Single symbol: ident 5, length 4, tick in LOAD ignored
        d0 = doneCnt;
        sendSymbol(3'd5, 32'd4);
        checkOutput("load_busy", busy, 1);
        applyStimulus("load_tick", 1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus($sformatf("t5_k%0d", k), 1'b1, expTone(toneA[k], k, 4));
        end
        for (int g = 0; g < 15; g++) begin
            applyStimulus($sformatf("t5_gap%0d", g), 1'b1, 0);
        end
        checkOutput("t5_no_early_done", doneCnt - d0, 0);
        applyStimulus("t5_gap15", 1'b1, 0);
        checkOutput("t5_done_once", doneCnt - d0, 1);
        checkOutput("t5_idle_busy", busy, 0);
        checkOutput("t5_idle_ready", ready, 1);

        // Back-to-back offers: ident 0 then ident 7
        d0 = doneCnt;
        sendSymbol(3'd0, 32'd4);
        a0        = acceptCnt;
        toneIdent = 3'd7;
        recLen    = 32'd4;
        toneValid = 1'b1;
        stepCycle();
        for (int k = 0; k < 4; k++) begin
            applyStimulus($sformatf("t0_k%0d", k), 1'b1, expTone(toneB[k], k, 4));
        end
        checkOutput("held_ready", ready, 0);
        checkOutput("held_no_accept", acceptCnt - a0, 0);
        checkOutput("held_offer_kept", toneValid, 1);
        gapTicks("t0");
        checkOutput("b2b_done", doneCnt - d0, 1);
        checkOutput("b2b_accept", acceptCnt - a0, 1);
        checkOutput("b2b_accept_after_done", doneAtAccept - d0, 1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus($sformatf("t7_k%0d", k), 1'b1, expTone(toneC[k], k, 4));
        end
        gapTicks("t7");
        checkOutput("t7_done", doneCnt - d0, 2);

        // Zero length with GAP_LEN=16: only gap zeros
        d0 = doneCnt;
        sendSymbol(3'd3, 32'd0);
        stepCycle();
        checkOutput("len0_busy", busy, 1);
        gapTicks("len0");
        checkOutput("len0_done", doneCnt - d0, 1);

        // Zero length with GAP_LEN=0: done two cycles after accept
        d0         = done0Cnt;
        recLen     = 32'd0;
        toneIdent  = 3'd2;
        toneValid0 = 1'b1;
        n          = 0;
        a0         = accept0Cnt;
        while (accept0Cnt == a0 && n < 20) begin
            stepCycle();
            n++;
        end
        checkOutput("gap0_accept", accept0Cnt - a0, 1);
        stepCycle();
        checkOutput("gap0_done_not_yet", done0, 0);
        stepCycle();
        checkOutput("gap0_done_pulse", done0, 1);
        checkOutput("gap0_no_sample", sampleValid0, 0);
        stepCycle();
        checkOutput("gap0_done_once", done0Cnt - d0, 1);
        checkOutput("gap0_busy", busy0, 0);

        // Full ROM sweep: 0, +full scale at k=8, 0 at k=16, -full scale at k=24
        d0 = doneCnt;
        sendSymbol(3'd5, 32'd25);
        stepCycle();
        for (int k = 0; k < 25; k++) begin
            applyStimulus($sformatf("sweep_k%0d", k), 1'b1, expTone(sweepBase(k), k, 25));
        end
        gapTicks("sweep");
        checkOutput("sweep_done", doneCnt - d0, 1);

        // Reset during PLAY of a length-100 symbol with a sample in flight
        sendSymbol(3'd5, 32'd100);
        stepCycle();
        applyStimulus("rst_k0", 1'b1, expTone(toneA[0], 0, 100));
        applyStimulus("rst_k1", 1'b1, expTone(toneA[1], 1, 100));
        tick = 1'b1;
        stepCycle();
        stepCycle();
        tick = 1'b0;
        for (int i = 2; i < LAT; i++) stepCycle();
        checkOutput("pre_rst_valid", sampleValid, 1);
        checkOutput("pre_rst_sample", sampleOut, expTone(toneA[2], 2, 100));
        d0 = doneCnt;
        #1;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", sampleValid, 0);
        checkOutput("mid_rst_sample", sampleOut, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_ready", ready, 0);
        stepCycle();
        stepCycle();
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            stepCycle();
            if (sampleValid) seen = 1'b1;
        end
        checkOutput("post_rst_no_valid", seen, 0);
        checkOutput("post_rst_no_done", doneCnt - d0, 0);
        sendSymbol(3'd5, 32'd4);
        stepCycle();
        applyStimulus("after_rst_k0", 1'b1, expTone(toneA[0], 0, 4));
        applyStimulus("after_rst_k1", 1'b1, expTone(toneA[1], 1, 4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
